// File: rtl/lc3_mem_access_if.sv
// Request and memory-bus bundle for the LC-3 memory-access sequencer.
// slave is the sequencer's view; master is the datapath/memory side.
interface lc3_mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic        req_indirect;
    logic [15:0] ea;
    logic [15:0] wdata;
    logic        done;
    logic [15:0] rsp_data;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  req_valid, req_store, req_indirect, ea, wdata, mem_rdata, mem_ready,
        output req_ready, done, rsp_data, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_indirect, ea, wdata, mem_rdata, mem_ready,
        input  req_ready, done, rsp_data, err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lc3_mem_access.sv
// LC-3 memory-access sequencer: LD/ST/LDR/STR/LDI/STI through MAR/MDR.
// Define LC3_MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES for mem_ready.
module lc3_mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst_n,
    lc3_mem_access_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StPtr, StAccess, StDone} stateT;

    stateT       stateQ, stateD;
    logic [15:0] marQ, marD;
    logic [15:0] mdrQ, mdrD;
    logic        storeQ, storeD;

`ifdef LC3_MEM_TIMEOUT_EN
    localparam int unsigned WaitW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WaitW-1:0] waitQ, waitD;
    logic [WaitW-1:0] waitInc;
    logic             errQ, errD;
    logic             timeoutHit;

    assign waitInc    = waitQ + WaitW'(1);
    assign timeoutHit = (waitInc == WaitW'(TIMEOUT_CYCLES));
`else
    logic [31:0] unusedTimeout;
    assign unusedTimeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            marQ   <= 16'h0000;
            mdrQ   <= 16'h0000;
            storeQ <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
            waitQ  <= '0;
            errQ   <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            marQ   <= marD;
            mdrQ   <= mdrD;
            storeQ <= storeD;
`ifdef LC3_MEM_TIMEOUT_EN
            waitQ  <= waitD;
            errQ   <= errD;
`endif
        end
    end

    always_comb begin
        stateD = stateQ;
        marD   = marQ;
        mdrD   = mdrQ;
        storeD = storeQ;
`ifdef LC3_MEM_TIMEOUT_EN
        waitD  = waitQ;
        errD   = errQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (bus.req_valid) begin
                    marD   = bus.ea;
                    mdrD   = bus.wdata;
                    storeD = bus.req_store;
                    stateD = bus.req_indirect ? StPtr : StAccess;
`ifdef LC3_MEM_TIMEOUT_EN
                    waitD  = '0;
                    errD   = 1'b0;
`endif
                end
            end
            StPtr: begin
                if (bus.mem_ready) begin
                    marD   = bus.mem_rdata;
                    stateD = StAccess;
`ifdef LC3_MEM_TIMEOUT_EN
                    waitD  = '0;
                end else if (timeoutHit) begin
                    // Pointer never arrived: skip the data access entirely.
                    mdrD   = 16'h0000;
                    errD   = 1'b1;
                    stateD = StDone;
                end else begin
                    waitD  = waitInc;
`endif
                end
            end
            StAccess: begin
                if (bus.mem_ready) begin
                    if (!storeQ) begin
                        mdrD = bus.mem_rdata;
                    end
                    stateD = StDone;
`ifdef LC3_MEM_TIMEOUT_EN
                end else if (timeoutHit) begin
                    mdrD   = 16'h0000;
                    errD   = 1'b1;
                    stateD = StDone;
                end else begin
                    waitD  = waitInc;
`endif
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Strobes come from the state register alone, never from req_valid or mem_ready.
    assign bus.req_ready = (stateQ == StIdle);
    assign bus.mem_en    = (stateQ == StPtr) || (stateQ == StAccess);
    assign bus.mem_we    = (stateQ == StAccess) && storeQ;
    assign bus.done      = (stateQ == StDone);
    assign bus.mem_addr  = marQ;
    assign bus.mem_wdata = mdrQ;
    assign bus.rsp_data  = mdrQ;
`ifdef LC3_MEM_TIMEOUT_EN
    assign bus.err       = (stateQ == StDone) && errQ;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
